// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave bridging the Cortex-M0 bus to a dual-port block RAM.
// Writes go out on port A during the AHB data phase; reads use the registered port B.
// A read of the word written in the immediately preceding transfer (read-after-write
// hazard) is resolved by byte-merge forwarding when BRAM_FWD_EN is defined, or by a
// one-cycle stall (RSTALL) when it is not.
module ahb_bram_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [31:0]           ram_dina,
   output logic [3:0]            ram_wea,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [31:0]           ram_doutb
);

   typedef enum logic [1:0] {StIdle, StWdata, StRdata, StRstall} state_e;

   state_e                  state_q, state_d;
   logic                    accept;
   logic                    hazard;
   logic [ADDR_WIDTH-1:0]   addr_word;
   logic [3:0]              mask;
   logic                    wr_pend_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic [3:0]              wr_mask_q;
   logic                    unused_bits;

   // Upper address bits are ignored so the RAM aliases across the address space.
   assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;
   assign addr_word = HADDR[ADDR_WIDTH+1:2];
   assign hazard    = accept & ~HWRITE & wr_pend_q & (addr_word == wr_addr_q);

   // Byte-lane mask from transfer size and low address bits; sizes above word act as word.
   always_comb begin
      mask = 4'b1111;
      case (HSIZE)
         3'd0:    mask = 4'b0001 << HADDR[1:0];
         3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

   // Capture the write address phase; wr_pend marks the following data-phase cycle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_pend_q <= 1'b0;
         wr_addr_q <= '0;
         wr_mask_q <= '0;
      end else begin
         wr_pend_q <= accept & HWRITE;
         if (accept & HWRITE) begin
            wr_addr_q <= addr_word;
            wr_mask_q <= mask;
         end
      end
   end

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: the data-phase state follows each accept; a stall always leads to RDATA.
   always_comb begin
      state_d = StIdle;
      if (accept) begin
         if (HWRITE) begin
            state_d = StWdata;
         end else begin
`ifdef BRAM_FWD_EN
            state_d = StRdata;
`else
            state_d = hazard ? StRstall : StRdata;
`endif
         end
      end else if (state_q == StRstall) begin
         state_d = StRdata;
      end
   end

   assign HREADYOUT = (state_q != StRstall);
   assign HRESP     = 1'b0;
   assign ram_addra = wr_addr_q;
   assign ram_dina  = HWDATA;
   // Reset clears wr_pend asynchronously, so an interrupted write never commits.
   assign ram_wea   = wr_pend_q ? wr_mask_q : 4'b0000;

`ifdef BRAM_FWD_EN
   logic [3:0]  fwd_mask_q;
   logic [31:0] fwd_data_q;

   // On a hazard, keep the in-flight write bytes so the read can see them next cycle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         fwd_mask_q <= '0;
         fwd_data_q <= '0;
      end else begin
         fwd_mask_q <= hazard ? wr_mask_q : 4'b0000;
         if (hazard) begin
            fwd_data_q <= HWDATA;
         end
      end
   end

   assign ram_addrb = addr_word;

   // Read data: forwarded bytes override the stale RAM bytes.
   always_comb begin
      HRDATA = ram_doutb;
      for (int i = 0; i < 4; i++) begin
         if (fwd_mask_q[i]) begin
            HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
         end
      end
   end
`else
   logic [ADDR_WIDTH-1:0] rd_addr_q;

   // Hold the read address so the stall cycle can re-issue it after the write commits.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_addr_q <= '0;
      end else if (accept & ~HWRITE) begin
         rd_addr_q <= addr_word;
      end
   end

   assign ram_addrb = (state_q == StRstall) ? rd_addr_q : addr_word;
   assign HRDATA    = ram_doutb;
`endif

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb_ahb_bram_ctrl: self-checking bench for ahb_bram_ctrl with a behavioural read-first RAM.
// Expected read data comes from a reference memory updated as writes are issued; reads push
// their expected word onto a queue that is popped when the read data phase completes.
module tb_ahb_bram_ctrl;

   localparam int unsigned AW = 10;
`ifdef BRAM_FWD_EN
   localparam int HAZ_STALL = 0;
`else
   localparam int HAZ_STALL = 1;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          HSEL = 1'b0;
   logic [31:0]   HADDR = '0;
   logic [1:0]    HTRANS = '0;
   logic [2:0]    HSIZE = 3'd2;
   logic          HWRITE = 1'b0;
   logic          HREADY;
   logic [31:0]   HWDATA = '0;
   logic [31:0]   HRDATA;
   logic          HREADYOUT;
   logic          HRESP;
   logic [AW-1:0] ram_addra;
   logic [31:0]   ram_dina;
   logic [3:0]    ram_wea;
   logic [AW-1:0] ram_addrb;
   logic [31:0]   ram_doutb;

   int compared = 0;
   int mismatched = 0;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic [31:0]   ref_mem [0:(1<<AW)-1];
   logic          ram_init = 1'b1;
   logic [31:0]   exp_q [$];
   logic [AW+3:0] wea_log [$];
   int            stall_cnt = 0;
   logic          rd_dphase = 1'b0;
   logic [31:0]   nxt_wdata = '0;

   always #5 HCLK = ~HCLK;

   // Single-slave system: the bus ready is this slave's ready.
   assign HREADY = HREADYOUT;

   ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HSIZE     (HSIZE),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_wea   (ram_wea),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb)
   );

   // Read-first dual-port RAM: port B returns the pre-write word on a same-edge collision.
   always @(posedge HCLK) begin
      if (ram_init) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= (i == 8) ? 32'h000000C3 : 32'hFFFFFFFF;
      end else begin
         for (int b = 0; b < 4; b++) if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
      end
      ram_doutb <= mem[ram_addrb];
   end

   function automatic logic [3:0] tb_mask(input logic [2:0] size, input logic [1:0] a);
      if (size == 3'd0) return 4'b0001 << a;
      else if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
      else return 4'b1111;
   endfunction

   // One AHB address phase (called at posedge+1); also runs the data phase of the previous one.
   task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
      int n;
      logic [3:0] m;
      logic [31:0] e;
      HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size; HWDATA = nxt_wdata;
      if (sel && trans[1]) begin
         if (wr) begin
            m = tb_mask(size, addr[1:0]);
            for (int b = 0; b < 4; b++) if (m[b]) ref_mem[addr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            exp_q.push_back(ref_mem[addr[AW+1:2]]);
         end
      end
      n = 0;
      do begin
         @(negedge HCLK);
         if (ram_wea != 4'b0000) wea_log.push_back({ram_wea, ram_addra});
         if (rd_dphase) begin
            if (!HREADYOUT) stall_cnt++;
            else if (exp_q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL rd_unexpected: got %h, want no read data phase", HRDATA);
            end else begin
               e = exp_q.pop_front();
               compared++;
               if (HRDATA !== e) begin
                  mismatched++;
                  $display("FAIL rd_data: got %h, want %h", HRDATA, e);
               end
            end
         end
         n++;
      end while (!HREADYOUT && n < 8);
      if (!HREADYOUT) begin
         compared++; mismatched++;
         $display("FAIL ready_timeout: got HREADYOUT=0 for %0d cycles, want at most %0d", n, HAZ_STALL);
      end
      @(posedge HCLK); #1;
      rd_dphase = sel & trans[1] & ~wr;
      nxt_wdata = wdata;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
      drive(1'b1, 2'b10, 1'b1, addr, size, d);
   endtask

   task automatic rd(input logic [31:0] addr);
      drive(1'b1, 2'b10, 1'b0, addr, 3'd2, 32'h0);
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      compared++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || ram_wea !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_outputs: got rdy=%b resp=%b wea=%b, want 1 0 0000", HREADYOUT, HRESP, ram_wea);
      end
      compared++;
      if (HRDATA !== 32'hFFFFFFFF) begin
         mismatched++;
         $display("FAIL reset_rdata: got %h, want ffffffff", HRDATA);
      end
      ram_init = 1'b0;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      compared++;
      if (HREADYOUT !== 1'b1 || ram_wea !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_idle: got rdy=%b wea=%b, want 1 0000", HREADYOUT, ram_wea);
      end
      @(posedge HCLK); #1;
   endtask

   task automatic test_word_rw();
      wea_log.delete(); stall_cnt = 0;
      wr(32'h10, 3'd2, 32'hDEADBEEF);
      idle();
      rd(32'h10);
      idle();
      idle();
      compared++;
      if (wea_log.size() != 1 || wea_log[0] !== {4'hF, 10'd4}) begin
         mismatched++;
         $display("FAIL word_wea: got %0d entries first %h, want 1 entry %h", wea_log.size(),
                  (wea_log.size() > 0) ? wea_log[0] : 14'h0, {4'hF, 10'd4});
      end
      compared++;
      if (stall_cnt != 0 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL word_rd_waits: got stalls=%0d left=%0d, want 0 0", stall_cnt, exp_q.size());
      end
   endtask

   task automatic test_byte_half();
      logic [AW+3:0] want [2];
      want[0] = {4'b0010, 10'd8};
      want[1] = {4'b1100, 10'd8};
      wea_log.delete(); stall_cnt = 0;
      wr(32'h21, 3'd0, 32'h0000AA00);
      wr(32'h22, 3'd1, 32'h12340000);
      idle();
      rd(32'h20);
      idle();
      compared++;
      if (wea_log.size() != 2) begin
         mismatched++;
         $display("FAIL bh_wea_count: got %0d, want 2", wea_log.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            compared++;
            if (wea_log[i] !== want[i]) begin
               mismatched++;
               $display("FAIL bh_wea%0d: got %h, want %h", i, wea_log[i], want[i]);
            end
         end
      end
      compared++;
      if (ref_mem[8] !== 32'h1234AAC3) begin
         mismatched++;
         $display("FAIL bh_model: got %h, want 1234aac3", ref_mem[8]);
      end
   endtask

   task automatic test_back_to_back();
      wr(32'h40, 3'd2, 32'hFFFFFFFF);
      idle();
      stall_cnt = 0;
      wr(32'h40, 3'd2, 32'h11111111);
      rd(32'h40);
      idle();
      idle();
      compared++;
      if (stall_cnt != HAZ_STALL || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL hazard_word: got stalls=%0d left=%0d, want %0d 0", stall_cnt, exp_q.size(), HAZ_STALL);
      end
      // Different-word write then read: no stall in either build.
      stall_cnt = 0;
      wr(32'h44, 3'd2, 32'h22222222);
      rd(32'h40);
      rd(32'h44);
      idle();
      compared++;
      if (stall_cnt != 0 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL b2b_nohazard: got stalls=%0d left=%0d, want 0 0", stall_cnt, exp_q.size());
      end
   endtask

   task automatic test_byte_fwd();
      wr(32'h40, 3'd2, 32'hFFFFFFFF);
      idle();
      stall_cnt = 0;
      wr(32'h41, 3'd0, 32'h00005500);
      rd(32'h40);
      idle();
      idle();
      compared++;
      if (stall_cnt != HAZ_STALL || ref_mem[16] !== 32'hFFFF55FF) begin
         mismatched++;
         $display("FAIL byte_fwd: got stalls=%0d model=%h, want %0d ffff55ff", stall_cnt, ref_mem[16], HAZ_STALL);
      end
   endtask

   task automatic test_wrap_size();
      wea_log.delete();
      wr(32'h1004, 3'd2, 32'hCAFEF00D);
      wr(32'h0C, 3'd4, 32'h600DF00D);
      idle();
      rd(32'h4);
      rd(32'hC);
      idle();
      compared++;
      if (wea_log.size() != 2 || wea_log[0] !== {4'hF, 10'd1} || wea_log[1] !== {4'hF, 10'd3}) begin
         mismatched++;
         $display("FAIL wrap_wea: got %0d entries first %h, want 2 entries %h %h", wea_log.size(),
                  (wea_log.size() > 0) ? wea_log[0] : 14'h0, {4'hF, 10'd1}, {4'hF, 10'd3});
      end
   endtask

   task automatic test_idle();
      wea_log.delete();
      wr(32'h50, 3'd2, 32'h0BADCAFE);
      drive(1'b0, 2'b10, 1'b1, 32'h54, 3'd2, 32'h99999999);
      drive(1'b1, 2'b01, 1'b1, 32'h54, 3'd2, 32'h99999999);
      drive(1'b1, 2'b00, 1'b0, 32'h54, 3'd2, 32'h0);
      rd(32'h50);
      rd(32'h54);
      idle();
      compared++;
      if (wea_log.size() != 1 || wea_log[0] !== {4'hF, 10'd20}) begin
         mismatched++;
         $display("FAIL idle_wea: got %0d entries first %h, want 1 entry %h", wea_log.size(),
                  (wea_log.size() > 0) ? wea_log[0] : 14'h0, {4'hF, 10'd20});
      end
      compared++;
      if (HRESP !== 1'b0 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL idle_resp: got resp=%b left=%0d, want 0 0", HRESP, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_write();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8; HSIZE = 3'd2; HWDATA = nxt_wdata;
      @(posedge HCLK); #1;
      HTRANS = 2'b00; HSEL = 1'b0; HWDATA = 32'h12345678;
      #2;
      compared++;
      if (ram_wea !== 4'hF) begin
         mismatched++;
         $display("FAIL rst_wdata_pre: got wea=%b, want 1111", ram_wea);
      end
      HRESETn = 1'b0;
      #1;
      compared++;
      if (ram_wea !== 4'b0000 || HREADYOUT !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_wdata_drop: got wea=%b rdy=%b, want 0000 1", ram_wea, HREADYOUT);
      end
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      rd_dphase = 1'b0; nxt_wdata = '0;
      rd(32'h8);
      idle();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL rst_wdata_read: got %0d pending reads, want 0", exp_q.size());
      end
   endtask

`ifndef BRAM_FWD_EN
   task automatic test_reset_rstall();
      wr(32'h80, 3'd2, 32'hA5A5A5A5);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h80; HSIZE = 3'd2; HWDATA = nxt_wdata;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      #1;
      compared++;
      if (HREADYOUT !== 1'b0) begin
         mismatched++;
         $display("FAIL rstall_enter: got rdy=%b, want 0", HREADYOUT);
      end
      HRESETn = 1'b0;
      #1;
      compared++;
      if (HREADYOUT !== 1'b1) begin
         mismatched++;
         $display("FAIL rstall_reset: got rdy=%b, want 1", HREADYOUT);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      rd_dphase = 1'b0; nxt_wdata = '0;
      rd(32'h80);
      idle();
   endtask
`endif

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = (i == 8) ? 32'h000000C3 : 32'hFFFFFFFF;
      test_reset();
      test_word_rw();
      test_byte_half();
      test_back_to_back();
      test_byte_fwd();
      test_wrap_size();
      test_idle();
      test_reset_mid_write();
`ifndef BRAM_FWD_EN
      test_reset_rstall();
`endif
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL final_queue: got %0d pending reads, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave that lets the Cortex-M0 bus master read and write the project's dual-port block RAM (write on port A, registered read on port B, per-byte write enables). It sits between the M0 bus matrix and the RAM macro. It decodes each AHB transfer into byte-lane write strobes or a port-B read, and returns read data with zero wait states. A read that immediately follows a write to the same word is handled by byte-merge forwarding or by a one-cycle stall.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM word-address width; uses HADDR[ADDR_WIDTH+1:2]; upper HADDR bits ignored, so addresses wrap.

Ports:
- HCLK  in  1  single clock; also clocks the RAM.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; NONSEQ/SEQ active, IDLE/BUSY ignored.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; values above 2 are treated as word.
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus ready.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  always 0 (OKAY).
- ram_addra  out  ADDR_WIDTH  RAM write word address.
- ram_dina  out  32  RAM write data.
- ram_wea  out  4  RAM byte write enables.
- ram_addrb  out  ADDR_WIDTH  RAM read word address.
- ram_doutb  in  32  RAM read data, registered, valid one cycle after ram_addrb.

## Operation
- A transfer is accepted when HSEL & HTRANS[1] & HREADY & HREADYOUT at a rising edge.
- Byte mask comes from HSIZE and HADDR[1:0]:
  - byte: 4'b0001 << HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Alignment is not checked.
- Write: the accept registers the word address (wr_addr_q) and the mask (wr_mask_q), and sets wr_pend. For the whole data-phase cycle: ram_addra = wr_addr_q, ram_dina = HWDATA, ram_wea = wr_mask_q. The RAM commits at the end of that cycle. At all other times ram_wea = 0.
- Read: ram_addrb = HADDR word index combinationally, so the RAM samples it at the accept edge. In the data phase, HRDATA = ram_doutb with all 4 bytes returned regardless of HSIZE.
- Hazard: a read is accepted while wr_pend is set and its word address equals wr_addr_q. The RAM read then returns pre-write data, so the hazard is resolved per Configuration.
- Read-read, write-write and write-to-read on different words need no special handling and run back to back with zero waits.
- States: IDLE, WDATA (write data phase), RDATA (read data phase), RSTALL (build without the macro only). The data-phase state follows each accept; IDLE follows a cycle with no accept.

## Timing
- Reset values (async, immediate): HREADYOUT = 1, HRESP = 0, ram_wea = 0, wr_pend = 0, forwarding mask = 0, state IDLE. HRDATA = ram_doutb.
- Zero-wait write: write data phase of 1 cycle; the RAM holds new data from the following edge.
- Zero-wait read: read data phase of 1 cycle; HRDATA valid in that cycle.
- HRESETn asserted during WDATA: ram_wea drops immediately and the write is lost. Reset during RDATA/RSTALL: HREADYOUT returns to 1.
- IDLE/BUSY transfers and HSEL = 0: OKAY, no RAM access, and a pending data phase still completes.

## Configuration
- BRAM_FWD_EN defined: on a hazard, register fwd_mask = wr_mask_q and capture fwd_data = HWDATA at the accept edge.
  - In the read data phase, HRDATA byte i = fwd_mask[i] ? fwd_data byte i : ram_doutb byte i.
  - Zero wait states; fwd_mask clears after the read data phase.
- BRAM_FWD_EN undefined: on a hazard, enter RSTALL.
  - HREADYOUT = 0 for one cycle, and ram_addrb = registered read address during that cycle.
  - The next cycle is RDATA with HREADYOUT = 1 and HRDATA = ram_doutb (post-write data).
  - Total read latency is 2 cycles. No forwarding registers are present.

## Test plan
- Reset: hold HRESETn = 0 -> HREADYOUT = 1, HRESP = 0, ram_wea = 0; release -> IDLE.
- Word write 0xDEADBEEF to 0x10, then after one IDLE cycle read 0x10 -> ram_wea = 4'hF with ram_addra = 4 in the write data phase; read returns 0xDEADBEEF with zero waits.
- Byte writes 0xAA to 0x21 and halfword 0x1234 to 0x22 -> ram_wea = 4'b0010 then 4'b1100; a word read of 0x20 returns 0x1234AAxx, where xx is the prior byte.
- Back-to-back word write 0x11111111 to 0x40 then read 0x40 (hazard), with prior content 0xFFFFFFFF:
  - with BRAM_FWD_EN: returns 0x11111111, HREADYOUT never low.
  - without BRAM_FWD_EN: one cycle with HREADYOUT = 0, then 0x11111111.
- Byte write 0x55 to 0x41 then immediate read 0x40 with forwarding, prior word 0xFFFFFFFF -> returns 0xFFFF55FF.
- Write to 0x1000 + 4 with ADDR_WIDTH = 10 -> ram_addra = 1 (wrap); HRESETn pulsed low mid-WDATA -> ram_wea = 0 immediately and the word is unchanged.
